digit_scan_sequencer: RTL
=========================

Name: digit_scan_sequencer

Overview:
Time-multiplexed scan sequencer for multi-digit displays. Steps a binary digit index that feeds directly into the binary-to-one-hot digit-select encoder, and presents the matching digit value alongside it. Each digit slot starts with a blanking interval so the segment lines never change while a digit is lit, which prevents ghosting. Digit data is snapshotted once per frame so a frame never shows a mix of old and new values.

Parameters:
DATA_WIDTH, 3, width of o_digit_idx; must equal the downstream encoder's DATA_WIDTH.
NUM_DIGITS, 8, digits scanned per frame; legal range 1..2^DATA_WIDTH.
DIGIT_BITS, 4, bits per digit value.
PRESCALE, 1000, clocks per digit slot, blank interval included; must be >= 2.
BLANK_CYCLES, 16, clocks per slot with o_digit_en low; legal range 1..PRESCALE-1.

Ports:
i_clk  in  1  system clock; all state updates on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_en  in  1  scan enable; level-sensitive.
i_digits  in  NUM_DIGITS*DIGIT_BITS  digit values; digit n occupies bits [n*DIGIT_BITS +: DIGIT_BITS].
o_digit_idx  out  DATA_WIDTH  binary index of the current digit; drives the one-hot encoder.
o_digit_val  out  DIGIT_BITS  value of the digit selected by o_digit_idx.
o_digit_en  out  1  high while the digit may be lit; downstream ANDs this with the one-hot select.
o_frame_start  out  1  one-clock pulse marking the start of a frame and a new snapshot.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - state=IDLE; o_digit_idx=0, o_digit_val=0, o_digit_en=0, o_frame_start=0.
  - Snapshot register and slot counter are cleared to 0.
- All outputs are registered. The slot counter is $clog2(PRESCALE) bits wide and counts 0..PRESCALE-1.
- States: IDLE, BLANK, SHOW.
- IDLE:
  - Outputs hold their reset values.
  - On an edge with i_en=1: capture i_digits into the snapshot, set idx=0, o_digit_val=i_digits[digit 0], o_frame_start=1, slot counter=0, go to BLANK.
- BLANK:
  - o_digit_en=0.
  - When the slot counter reaches BLANK_CYCLES-1, go to SHOW; o_digit_en becomes 1 on that same edge.
- SHOW:
  - o_digit_en=1.
  - When the slot counter reaches PRESCALE-1 (end of slot): counter goes to 0, o_digit_en goes to 0, state goes to BLANK.
  - If idx < NUM_DIGITS-1: idx increments and o_digit_val loads the snapshot value for the new idx.
  - If idx == NUM_DIGITS-1 (wrap): idx goes to 0, the snapshot recaptures i_digits, o_digit_val loads the new digit 0, and o_frame_start pulses.
- Update rule: o_digit_idx and o_digit_val change only on edges where o_digit_en is 0 or is falling to 0. They are always stable for the whole lit window.
- o_frame_start: high exactly one clock per frame, otherwise 0.
- Timing, with i_en sampled high at edge k:
  - o_frame_start high for the cycle after edge k only.
  - o_digit_en rises after edge k+BLANK_CYCLES and falls after edge k+PRESCALE.
  - idx=1 after edge k+PRESCALE.
  - Frame period is NUM_DIGITS*PRESCALE clocks.
- NUM_DIGITS=1: idx stays 0; every slot is a wrap, so a recapture and an o_frame_start pulse occur every PRESCALE clocks.
- Changes on i_digits between snapshots have no effect on the outputs until the next frame start.
- i_en low on any edge, in any state: go to IDLE and return every output to its reset value on that edge. Any o_frame_start pulse due on that edge is suppressed.
- i_en low then high again: restarts from digit 0 with a fresh snapshot, never resuming mid-frame.
- Reset asserted mid-slot: outputs clear immediately without waiting for a clock edge. After release, the block waits in IDLE for i_en.

Test Plan:
- Parameters NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2, i_digits=16'h4321. Raise i_en -> idx sequence 0,1,2,3,0 with 8 clocks per slot; o_digit_val 1,2,3,4 with each value matching its idx; o_digit_en low 2 clocks then high 6 clocks in every slot; o_frame_start high 1 clock every 32 clocks.
- Change i_digits to 16'hABCD while idx=2 -> digits 2 and 3 still show 3 and 4; after the wrap, digit 0 shows D and the frame_start pulse coincides with that recapture.
- Drop i_en while in SHOW with idx=2 -> next edge gives idx=0, o_digit_en=0, val=0. Re-raise i_en -> o_frame_start pulses and the scan restarts at digit 0 with the blank interval first.
- Assert i_rst_n low between clock edges mid-slot -> all outputs read 0 before the next edge. Hold i_en=1 through the reset release -> scan restarts from digit 0.
- Parameters NUM_DIGITS=1, PRESCALE=4, BLANK_CYCLES=1 -> idx constant 0; o_frame_start pulses every 4 clocks; o_digit_en pattern 0,1,1,1 repeating.
- Feed o_digit_idx into the one-hot encoder and check one_hot AND o_digit_en over a whole frame -> at most one bit high at any time; no idx or val change ever occurs in a cycle where o_digit_en is 1.

Source files
------------

// File: rtl/digit_scan_sequencer.sv
// digit_scan_sequencer
// Time-multiplexed display scan. Each digit slot is PRESCALE clocks: a
// BLANK_CYCLES blanking interval with o_digit_en low, then the lit window.
// The digit index and value only move while the digit is dark, so the
// segment lines never change under a lit digit. Digit data is snapshotted
// at each frame start so a frame never mixes old and new values.
module digit_scan_sequencer #(
    parameter int DATA_WIDTH   = 3,
    parameter int NUM_DIGITS   = 8,
    parameter int DIGIT_BITS   = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_en,
    input  logic [NUM_DIGITS*DIGIT_BITS-1:0] i_digits,
    output logic [DATA_WIDTH-1:0]            o_digit_idx,
    output logic [DIGIT_BITS-1:0]            o_digit_val,
    output logic                             o_digit_en,
    output logic                             o_frame_start
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int SNAP_W = NUM_DIGITS * DIGIT_BITS;

    localparam logic [CNT_W-1:0]      CNT_SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]      CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] IDX_LAST       = DATA_WIDTH'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_idx;
    logic [DIGIT_BITS-1:0]   r_val;
    logic                    r_en;
    logic                    r_fs;
    logic [SNAP_W-1:0]       r_snap;

    logic [CNT_W-1:0]        w_cnt_nxt;
    logic [DATA_WIDTH-1:0]   w_idx_nxt;
    logic [DIGIT_BITS-1:0]   w_val_nxt;
    logic                    w_en_nxt;
    logic                    w_fs_nxt;
    logic [SNAP_W-1:0]       w_snap_nxt;

    logic                    w_slot_end;
    logic                    w_blank_end;
    logic                    w_wrap;
    logic [DATA_WIDTH-1:0]   w_idx_inc;
    logic [DIGIT_BITS-1:0]   w_next_val;

    assign w_slot_end  = (r_cnt == CNT_SLOT_LAST);
    assign w_blank_end = (r_cnt == CNT_BLANK_LAST);
    assign w_wrap      = (r_idx == IDX_LAST);
    assign w_idx_inc   = r_idx + DATA_WIDTH'(1);

    // Snapshot lookup for the digit that follows the current one; only used
    // when the slot does not wrap, so w_idx_inc is always a legal digit there.
    always_comb begin
        w_next_val = '0;
        for (int n = 0; n < NUM_DIGITS; n++) begin
            if (w_idx_inc == DATA_WIDTH'(n))
                w_next_val = r_snap[n*DIGIT_BITS +: DIGIT_BITS];
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; dropping i_en returns to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        if (!i_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_BLANK;
                S_BLANK: if (w_blank_end) w_state_nxt = S_SHOW;
                S_SHOW:  if (w_slot_end)  w_state_nxt = S_BLANK;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values; idx and val only move on the edge that
    // starts a new slot, which is also the edge where o_digit_en drops.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_idx_nxt  = r_idx;
        w_val_nxt  = r_val;
        w_en_nxt   = r_en;
        w_fs_nxt   = 1'b0;
        w_snap_nxt = r_snap;
        if (!i_en) begin
            // Abort: everything visible goes back to its reset value and any
            // frame-start due on this edge is suppressed.
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_val_nxt = '0;
            w_en_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Fresh start always begins a new frame from digit 0.
                    w_snap_nxt = i_digits;
                    w_idx_nxt  = '0;
                    w_val_nxt  = i_digits[DIGIT_BITS-1:0];
                    w_fs_nxt   = 1'b1;
                    w_cnt_nxt  = '0;
                    w_en_nxt   = 1'b0;
                end
                S_BLANK: begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_en_nxt  = w_blank_end;
                end
                S_SHOW: begin
                    if (w_slot_end) begin
                        w_cnt_nxt = '0;
                        w_en_nxt  = 1'b0;
                        if (w_wrap) begin
                            w_idx_nxt  = '0;
                            w_snap_nxt = i_digits;
                            w_val_nxt  = i_digits[DIGIT_BITS-1:0];
                            w_fs_nxt   = 1'b1;
                        end else begin
                            w_idx_nxt = w_idx_inc;
                            w_val_nxt = w_next_val;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        w_en_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    w_val_nxt = '0;
                    w_en_nxt  = 1'b0;
                end
            endcase
        end
    end

    // Registered outputs, slot counter and frame snapshot.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_idx  <= '0;
            r_val  <= '0;
            r_en   <= 1'b0;
            r_fs   <= 1'b0;
            r_snap <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idx  <= w_idx_nxt;
            r_val  <= w_val_nxt;
            r_en   <= w_en_nxt;
            r_fs   <= w_fs_nxt;
            r_snap <= w_snap_nxt;
        end
    end

    assign o_digit_idx   = r_idx;
    assign o_digit_val   = r_val;
    assign o_digit_en    = r_en;
    assign o_frame_start = r_fs;

endmodule
